// File: rtl/fft16_radix4_top.sv
// Purpose : 16-point complex FFT demo core, two radix-4 stages, fixed point,
//           fed from an internal ROM (x[n] = n, imag = 0) by caller-driven address.
// Latency : all 16 bins appear 2 clocks after the clock that captures address 15.
// Backpressure: none. One capture per clock; outputs hold until the next frame lands.
//
// Ports:
//   clk                  clock, all state on rising edge
//   reset                synchronous active-high reset. Clears buffer, pipeline and outputs.
//   address[3:0]         ROM/buffer index captured this cycle
//   out_re0..out_re15    Re X[K], natural order, DW bits, two's complement
//   out_im0..out_im15    Im X[K], natural order, DW bits, two's complement
//
// Build option: define FFT_STAGE_SCALE_EN to arithmetic-shift each stage result
// right by 2, which gives a total scale of 1/16 and cannot overflow.
// The default build has no scaling and produces raw DFT sums that wrap to DW bits.

module fft16_radix4_top #(
  parameter int DW = 16,  // sample/output width
  parameter int IW = 20,  // internal stage width (DW + 4 guard bits)
  parameter int TW = 16   // twiddle width, Q1.14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    address,
  output logic [DW-1:0] out_re0,
  output logic [DW-1:0] out_re1,
  output logic [DW-1:0] out_re2,
  output logic [DW-1:0] out_re3,
  output logic [DW-1:0] out_re4,
  output logic [DW-1:0] out_re5,
  output logic [DW-1:0] out_re6,
  output logic [DW-1:0] out_re7,
  output logic [DW-1:0] out_re8,
  output logic [DW-1:0] out_re9,
  output logic [DW-1:0] out_re10,
  output logic [DW-1:0] out_re11,
  output logic [DW-1:0] out_re12,
  output logic [DW-1:0] out_re13,
  output logic [DW-1:0] out_re14,
  output logic [DW-1:0] out_re15,
  output logic [DW-1:0] out_im0,
  output logic [DW-1:0] out_im1,
  output logic [DW-1:0] out_im2,
  output logic [DW-1:0] out_im3,
  output logic [DW-1:0] out_im4,
  output logic [DW-1:0] out_im5,
  output logic [DW-1:0] out_im6,
  output logic [DW-1:0] out_im7,
  output logic [DW-1:0] out_im8,
  output logic [DW-1:0] out_im9,
  output logic [DW-1:0] out_im10,
  output logic [DW-1:0] out_im11,
  output logic [DW-1:0] out_im12,
  output logic [DW-1:0] out_im13,
  output logic [DW-1:0] out_im14,
  output logic [DW-1:0] out_im15
);

  // Product width: full IW x TW signed product plus one bit for the sum of two products.
  localparam int PW = IW + TW + 1;

  typedef struct packed {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
  } cplx_t;

  // Sample ROM: entry n holds the real value n.
  function automatic logic signed [DW-1:0] rom_sample(input logic [3:0] a);
    return DW'({1'b0, a});
  endfunction

  // Radix-4 butterfly, output p of (a, b, c, d):
  //   p=0: a +  b + c +  d
  //   p=1: a - jb - c + jd
  //   p=2: a -  b + c -  d
  //   p=3: a + jb - c - jd
  // -j*(x+jy) = y - jx, j*(x+jy) = -y + jx.
  function automatic cplx_t bfly(input cplx_t a, input cplx_t b, input cplx_t c,
                                 input cplx_t d, input logic [1:0] p);
    cplx_t r;
    case (p)
      2'd0: begin
        r.re = a.re + b.re + c.re + d.re;
        r.im = a.im + b.im + c.im + d.im;
      end
      2'd1: begin
        r.re = a.re + b.im - c.re - d.im;
        r.im = a.im - b.re - c.im + d.re;
      end
      2'd2: begin
        r.re = a.re - b.re + c.re - d.re;
        r.im = a.im - b.im + c.im - d.im;
      end
      default: begin
        r.re = a.re - b.im - c.re + d.im;
        r.im = a.im + b.re - c.im - d.re;
      end
    endcase
    return r;
  endfunction

  // Multiply by W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16).
  // Quarter-turn twiddles (k = 0, 4, 8, 12) are exact sign/swap operations.
  // The remaining twiddles use Q1.14 constants, and each product sum is rounded half-up.
  function automatic cplx_t twiddle_mul(input cplx_t z, input logic [3:0] k);
    logic signed [TW-1:0] wc;
    logic signed [TW-1:0] ws;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    cplx_t r;
    wc = '0;
    ws = '0;
    case (k)
      4'd1:    begin wc = TW'(15137);  ws = TW'(6270);   end
      4'd2:    begin wc = TW'(11585);  ws = TW'(11585);  end
      4'd3:    begin wc = TW'(6270);   ws = TW'(15137);  end
      4'd5:    begin wc = TW'(-6270);  ws = TW'(15137);  end
      4'd6:    begin wc = TW'(-11585); ws = TW'(11585);  end
      4'd7:    begin wc = TW'(-15137); ws = TW'(6270);   end
      4'd9:    begin wc = TW'(-15137); ws = TW'(-6270);  end
      4'd10:   begin wc = TW'(-11585); ws = TW'(-11585); end
      4'd11:   begin wc = TW'(-6270);  ws = TW'(-15137); end
      4'd13:   begin wc = TW'(6270);   ws = TW'(-15137); end
      4'd14:   begin wc = TW'(11585);  ws = TW'(-11585); end
      4'd15:   begin wc = TW'(15137);  ws = TW'(-6270);  end
      default: begin wc = '0;          ws = '0;          end
    endcase
    // (zr + j zi)(c - j s) = (zr*c + zi*s) + j(zi*c - zr*s)
    pr = PW'($signed(z.re)) * PW'(wc) + PW'($signed(z.im)) * PW'(ws);
    pi = PW'($signed(z.im)) * PW'(wc) - PW'($signed(z.re)) * PW'(ws);
    case (k)
      4'd0:  r = z;
      4'd4:  begin r.re = z.im;  r.im = -z.re; end  // -j
      4'd8:  begin r.re = -z.re; r.im = -z.im; end  // -1
      4'd12: begin r.re = -z.im; r.im = z.re;  end  // +j
      default: begin
        r.re = IW'((pr + PW'(8192)) >>> 14);
        r.im = IW'((pi + PW'(8192)) >>> 14);
      end
    endcase
    return r;
  endfunction

  // Optional per-stage normalisation.
  function automatic cplx_t stage_scale(input cplx_t z);
`ifdef FFT_STAGE_SCALE_EN
    cplx_t r;
    r.re = $signed(z.re) >>> 2;
    r.im = $signed(z.im) >>> 2;
    return r;
`else
    return z;
`endif
  endfunction

  logic signed [DW-1:0] frame_buf [16];
  logic                 frame_done;   // address 15 was captured last clock
  logic                 s1_vld;       // stage-1 regs hold a fresh frame
  cplx_t                x_in      [16];
  cplx_t                s1_nxt    [16];
  cplx_t                s1_q      [16];  // index 4*n + m
  cplx_t                s2_nxt    [16];  // natural-order bins
  logic    [DW-1:0]     out_re_q  [16];
  logic    [DW-1:0]     out_im_q  [16];

  // Buffer entries extended to the internal width. The imaginary part is always 0.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      x_in[i].re = IW'(frame_buf[i]);
      x_in[i].im = '0;
    end
  end

  // Stage 1: butterfly n works on (n, n+4, n+8, n+12). Output m is rotated by W16^(n*m).
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      for (int m = 0; m < 4; m++) begin
        s1_nxt[4*n+m] = stage_scale(twiddle_mul(
            bfly(x_in[n], x_in[n+4], x_in[n+8], x_in[n+12], 2'(m)), 4'(n*m)));
      end
    end
  end

  // Stage 2: group m gathers the m-th output of every stage-1 butterfly.
  // Its butterfly output p is bin m + 4p, and writing to that index performs the digit reversal.
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      for (int p = 0; p < 4; p++) begin
        s2_nxt[m+4*p] = stage_scale(bfly(s1_q[m], s1_q[4+m], s1_q[8+m], s1_q[12+m], 2'(p)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      s1_vld     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        frame_buf[i] <= '0;
        s1_q[i]      <= '0;
        out_re_q[i]  <= '0;
        out_im_q[i]  <= '0;
      end
    end else begin
      frame_buf[address] <= rom_sample(address);
      frame_done         <= (address == 4'd15);
      s1_vld             <= frame_done;
      // Stage 1 reads the buffer, including the sample captured on the frame_done edge.
      // A capture made on this same edge does not reach stage 1 until the next frame.
      if (frame_done) begin
        for (int i = 0; i < 16; i++) s1_q[i] <= s1_nxt[i];
      end
      // Final truncation to DW bits wraps on overflow.
      if (s1_vld) begin
        for (int i = 0; i < 16; i++) begin
          out_re_q[i] <= DW'(s2_nxt[i].re);
          out_im_q[i] <= DW'(s2_nxt[i].im);
        end
      end
    end
  end

  assign out_re0  = out_re_q[0];
  assign out_re1  = out_re_q[1];
  assign out_re2  = out_re_q[2];
  assign out_re3  = out_re_q[3];
  assign out_re4  = out_re_q[4];
  assign out_re5  = out_re_q[5];
  assign out_re6  = out_re_q[6];
  assign out_re7  = out_re_q[7];
  assign out_re8  = out_re_q[8];
  assign out_re9  = out_re_q[9];
  assign out_re10 = out_re_q[10];
  assign out_re11 = out_re_q[11];
  assign out_re12 = out_re_q[12];
  assign out_re13 = out_re_q[13];
  assign out_re14 = out_re_q[14];
  assign out_re15 = out_re_q[15];
  assign out_im0  = out_im_q[0];
  assign out_im1  = out_im_q[1];
  assign out_im2  = out_im_q[2];
  assign out_im3  = out_im_q[3];
  assign out_im4  = out_im_q[4];
  assign out_im5  = out_im_q[5];
  assign out_im6  = out_im_q[6];
  assign out_im7  = out_im_q[7];
  assign out_im8  = out_im_q[8];
  assign out_im9  = out_im_q[9];
  assign out_im10 = out_im_q[10];
  assign out_im11 = out_im_q[11];
  assign out_im12 = out_im_q[12];
  assign out_im13 = out_im_q[13];
  assign out_im14 = out_im_q[14];
  assign out_im15 = out_im_q[15];

endmodule

// File: tb/tb_fft16_radix4_top.sv
// Purpose : self-checking bench for fft16_radix4_top.
// Latency : the bench reference expects bins 2 clocks after capture of address 15.
// Backpressure: none. One address is driven per clock.

module tb_fft16_radix4_top;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic [15:0] o_re [16];
  logic [15:0] o_im [16];

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents, a 2-deep delay of computed spectra, and the visible outputs.
  int mbuf   [16];
  int p1_re  [16], p1_im [16], p2_re [16], p2_im [16];
  int exp_re [16], exp_im [16];
  bit p1_vld, p2_vld;

  typedef struct {
    int bin;
    bit im;
    int want;
    int tol;
  } vec_t;
  vec_t tab [10];
  int   ntab;

  fft16_radix4_top dut (
    .clk(clk), .reset(reset), .address(address),
    .out_re0(o_re[0]),   .out_re1(o_re[1]),   .out_re2(o_re[2]),   .out_re3(o_re[3]),
    .out_re4(o_re[4]),   .out_re5(o_re[5]),   .out_re6(o_re[6]),   .out_re7(o_re[7]),
    .out_re8(o_re[8]),   .out_re9(o_re[9]),   .out_re10(o_re[10]), .out_re11(o_re[11]),
    .out_re12(o_re[12]), .out_re13(o_re[13]), .out_re14(o_re[14]), .out_re15(o_re[15]),
    .out_im0(o_im[0]),   .out_im1(o_im[1]),   .out_im2(o_im[2]),   .out_im3(o_im[3]),
    .out_im4(o_im[4]),   .out_im5(o_im[5]),   .out_im6(o_im[6]),   .out_im7(o_im[7]),
    .out_im8(o_im[8]),   .out_im9(o_im[9]),   .out_im10(o_im[10]), .out_im11(o_im[11]),
    .out_im12(o_im[12]), .out_im13(o_im[13]), .out_im14(o_im[14]), .out_im15(o_im[15])
  );

  always #5 clk = ~clk;

  function automatic int sgn(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Allowed error per bin. Bins 0, 4, 8 and 12 only involve exact twiddles.
  function automatic int tol_for(input int k);
`ifdef FFT_STAGE_SCALE_EN
    return 3;
`else
    return (k % 4 == 0) ? 0 : 2;
`endif
  endfunction

  // Direct 16-point DFT of the model buffer, in floating point.
  task automatic model_dft();
    real sr, si, ang, sc;
`ifdef FFT_STAGE_SCALE_EN
    sc = 16.0;
`else
    sc = 1.0;
`endif
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 2.0 * PI * real'(n * k) / 16.0;
        sr  = sr + real'(mbuf[n]) * $cos(ang);
        si  = si - real'(mbuf[n]) * $sin(ang);
      end
      p1_re[k] = rnd(sr / sc);
      p1_im[k] = rnd(si / sc);
    end
  endtask

  // Effect of one rising edge with inputs (a, r).
  task automatic model_edge(input logic [3:0] a, input bit r);
    if (r) begin
      for (int k = 0; k < 16; k++) begin
        mbuf[k] = 0; exp_re[k] = 0; exp_im[k] = 0;
      end
      p1_vld = 0;
      p2_vld = 0;
    end else begin
      if (p2_vld) begin
        exp_re = p2_re;
        exp_im = p2_im;
      end
      p2_vld = p1_vld;
      p2_re  = p1_re;
      p2_im  = p1_im;
      mbuf[a] = int'(a);
      p1_vld = (a == 4'd15);
      if (p1_vld) model_dft();
    end
  endtask

  // Drive one clock. Inputs change at the negedge, and the bench samples at the following negedge.
  task automatic cyc(input logic [3:0] a, input bit r);
    address = a;
    reset   = r;
    @(negedge clk);
    model_edge(a, r);
  endtask

  task automatic chk(input string nm, input int k, input int act, input int want, input int tol);
    total++;
    if (act > want + tol || act < want - tol) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d, want %0d (+/-%0d)", nm, k, act, want, tol);
    end
  endtask

  task automatic chk_model(input string nm);
    for (int k = 0; k < 16; k++) begin
      chk({nm, "_re"}, k, sgn(o_re[k]), exp_re[k], tol_for(k));
      chk({nm, "_im"}, k, sgn(o_im[k]), exp_im[k], tol_for(k));
    end
  endtask

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 16; k++) begin
      chk({nm, "_re"}, k, sgn(o_re[k]), 0, 0);
      chk({nm, "_im"}, k, sgn(o_im[k]), 0, 0);
    end
  endtask

  task automatic run_table(input string nm);
    int act;
    for (int i = 0; i < ntab; i++) begin
      act = tab[i].im ? sgn(o_im[tab[i].bin]) : sgn(o_re[tab[i].bin]);
      chk(tab[i].im ? {nm, "_im"} : {nm, "_re"}, tab[i].bin, act, tab[i].want, tab[i].tol);
    end
  endtask

  initial begin
`ifdef FFT_STAGE_SCALE_EN
    tab[0] = '{0, 1'b0, 7, 0};
    tab[1] = '{0, 1'b1, 0, 0};
    ntab = 2;
`else
    tab[0] = '{0,  1'b0, 120, 0};
    tab[1] = '{0,  1'b1, 0,   0};
    tab[2] = '{8,  1'b0, -8,  0};
    tab[3] = '{8,  1'b1, 0,   0};
    tab[4] = '{4,  1'b0, -8,  0};
    tab[5] = '{4,  1'b1, 8,   0};
    tab[6] = '{12, 1'b0, -8,  0};
    tab[7] = '{12, 1'b1, -8,  0};
    tab[8] = '{2,  1'b0, -8,  1};
    tab[9] = '{2,  1'b1, 19,  1};
    ntab = 10;
`endif

    // Reset held for 2 cycles: every output reads 0.
    cyc(4'd0, 1'b1);
    cyc(4'd0, 1'b1);
    chk_zero("reset");

    // Ascending frame. One clock after address 15 the outputs have not moved yet.
    for (int a = 0; a < 16; a++) cyc(4'(a), 1'b0);
    cyc(4'd0, 1'b0);
    chk("latency_re0", 0, sgn(o_re[0]), 0, 0);
    cyc(4'd1, 1'b0);
    run_table("asc");
    chk_model("asc");

    // Continuous wrap. Outputs hold through the next frame and are then refreshed identically.
    for (int a = 2; a < 16; a++) begin
      cyc(4'(a), 1'b0);
      chk_model("wrap_hold");
    end
    cyc(4'd0, 1'b0);
    cyc(4'd1, 1'b0);
    run_table("wrap");

    // Load 0..6, then reset while address=7 so 7 is dropped. Then capture 8..15.
    for (int a = 2; a < 7; a++) cyc(4'(a), 1'b0);
    cyc(4'd7, 1'b1);
    chk_zero("rst7_clear");
    for (int a = 8; a < 16; a++) cyc(4'(a), 1'b0);
    cyc(4'd0, 1'b0);
    cyc(4'd0, 1'b0);
`ifdef FFT_STAGE_SCALE_EN
    chk_model("rst7");
`else
    chk("rst7_re0", 0, sgn(o_re[0]), 92, 0);
    chk_model("rst7");
`endif

    // Only sample 15 is present in the buffer.
    cyc(4'd15, 1'b1);
    cyc(4'd15, 1'b0);
    cyc(4'd15, 1'b0);
    cyc(4'd15, 1'b0);
`ifndef FFT_STAGE_SCALE_EN
    chk("only15_re0", 0, sgn(o_re[0]), 15, 0);
    chk("only15_im0", 0, sgn(o_im[0]), 0, 0);
    chk("only15_re8", 8, sgn(o_re[8]), -15, 0);
    chk("only15_re4", 4, sgn(o_re[4]), 0, 0);
    chk("only15_im4", 4, sgn(o_im[4]), 15, 0);
`endif
    chk_model("only15");

    // Reset right after a capture of 15: the in-flight frame must not reappear.
    cyc(4'd15, 1'b0);
    cyc(4'd0, 1'b1);
    chk_zero("abort0");
    for (int i = 0; i < 3; i++) begin
      cyc(4'd0, 1'b0);
      chk_zero("abort");
    end

    // Random address stream with occasional resets, checked against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
      chk_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
